demux2: RTL and testbench
=========================

Name: demux2

Overview:
- Registered 1-to-2 stream demultiplexer with valid/ready handshakes; the inverse direction of the 2-to-1 mux.
- Routes each accepted input word to output 0 or 1 according to select_i, buffering per output in a small FIFO.
- Sits between a single producer (e.g. a load/store or writeback source) and two independent consumers.
- Upstream is decoupled from each consumer's stall timing.

Parameters:
- Width, 32, data bits per word.
- Depth, 2, entries per output FIFO; power of two, at least 2.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous active-high reset.
- data_i  input  Width  input word.
- select_i  input  1  destination: 0 means output 0, 1 means output 1; qualified by valid_i.
- valid_i  input  1  input word present.
- ready_o  output  1  selected destination FIFO can accept.
- data0_o  output  Width  head word of FIFO 0.
- valid0_o  output  1  FIFO 0 non-empty.
- ready0_i  input  1  consumer 0 accepts.
- data1_o  output  Width  head word of FIFO 1.
- valid1_o  output  1  FIFO 1 non-empty.
- ready1_i  input  1  consumer 1 accepts.

Behaviour:
- Reset (rst_i high at a rising edge):
  - Both FIFOs empty: read/write pointers = 0, count = 0.
  - valid0_o = valid1_o = 0.
  - data0_o = data1_o = 0.
  - Reset overrides any handshake in the same cycle. A word offered or pending mid-operation is dropped, with no partial state.
- Per-output FIFO k (k = 0, 1):
  - count_k ranges 0..Depth.
  - full_k = (count_k == Depth); empty_k = (count_k == 0).
  - Pointers are log2(Depth) bits and wrap naturally from Depth-1 to 0.
- ready_o = select_i ? ~full_1 : ~full_0.
  - Combinational from select_i and registered count only.
  - No combinational path from ready0_i or ready1_i to ready_o.
- Input transfer = valid_i & ready_o. It writes data_i into FIFO select_i at the rising edge; the other FIFO is untouched.
- Output transfer k = valid_k_o & readyk_i. It advances FIFO k's read pointer at the rising edge.
- valid_k_o = ~empty_k; data_k_o = entry at FIFO k's read pointer.
  - data_k_o is 0 while empty after reset.
  - After a drain, data_k_o is don't-care; benches check data only when valid.
- Latency: a word accepted at edge N is visible on its output at edge N (valid high in the following cycle). Minimum latency is 1 cycle; there is no same-cycle bypass.
- Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.
  - When full, no push occurs (ready_o low) even if a pop happens the same cycle. The slot frees on the next cycle.
- Simultaneous events across FIFOs are fully independent. Pushing FIFO 0 while popping FIFO 1 is legal each cycle.
- Ordering:
  - Words to the same output leave in acceptance order.
  - There is no ordering guarantee between outputs.
- Throughput: one input word per cycle while the selected FIFO is not full. Each output delivers one word per cycle while non-empty and ready.
- Producer protocol:
  - Once valid_i is asserted, the producer may change select_i or data_i only after a transfer.
  - This block does not enforce the rule. It simply samples select_i, data_i and ready_o in the transfer cycle.
- Words are never duplicated, reordered within an output, or lost, except by reset.

Test Plan:
- Reset, then idle: rst_i=1 for 2 cycles -> valid0_o=valid1_o=0, data0_o=data1_o=0, ready_o=1 for both select values.
- Alternating routing, both consumers always ready: push 0xA0 (sel 0), 0xB1 (sel 1), 0xA2 (sel 0) on consecutive cycles.
  - Expect data0_o 0xA0 then 0xA2, data1_o 0xB1.
  - Each word appears exactly 1 cycle after its acceptance.
- Fill and stall, Depth=2: ready0_i=0, push 0x11, 0x22 to output 0.
  - Third offer 0x33 (sel 0) sees ready_o=0.
  - Offering the same cycle with sel 1 sees ready_o=1.
  - Raise ready0_i -> 0x11, 0x22, then 0x33 (after acceptance) emerge in order.
- Full with simultaneous pop: FIFO 1 full, ready1_i=1, valid_i=1 sel 1 -> no push that cycle (ready_o=0); the push is accepted next cycle; count never exceeds 2.
- Streaming wrap-around: 10 words 0x0..0x9 to output 1 with ready1_i toggling 1,0,1,0 -> output 1 delivers exactly 0x0..0x9 in order; output 0 never asserts valid.
- Reset mid-operation: both FIFOs holding 1 word, rst_i=1 while valid_i=1 -> after reset both valids are 0, the offered word is discarded, and the next push is delivered normally.

Source files
------------

// File: rtl/demux2_if.sv
// demux2_if: bundles the producer-side stream and the two consumer-side
// streams of the 1-to-2 demultiplexer.
//   data_i/select_i/valid_i/ready_o : single input stream; select_i picks output
//   data0_o/valid0_o/ready0_i       : output stream 0
//   data1_o/valid1_o/ready1_i       : output stream 1
// Port suffixes are from the demux's point of view.
// slave  : modport used by the demux itself.
// master : modport used by the surrounding producer and consumers.
interface demux2_if #(
    parameter int Width = 32
);
    logic [Width-1:0] data_i;
    logic             select_i;
    logic             valid_i;
    logic             ready_o;

    logic [Width-1:0] data0_o;
    logic             valid0_o;
    logic             ready0_i;

    logic [Width-1:0] data1_o;
    logic             valid1_o;
    logic             ready1_i;

    modport slave (
        input  data_i, select_i, valid_i,
        output ready_o,
        output data0_o, valid0_o,
        input  ready0_i,
        output data1_o, valid1_o,
        input  ready1_i
    );

    modport master (
        output data_i, select_i, valid_i,
        input  ready_o,
        input  data0_o, valid0_o,
        output ready0_i,
        input  data1_o, valid1_o,
        output ready1_i
    );
endinterface

// File: rtl/demux2.sv
// demux2: registered 1-to-2 stream demultiplexer.
// Each accepted input word is written into the FIFO chosen by select_i. Each
// output stream presents the head of its own FIFO, so the producer is
// decoupled from the stall timing of either consumer.
// Ports:
//   clk_i : clock, all state changes on the rising edge
//   rst_i : synchronous active-high reset (empties both FIFOs)
//   bus   : demux2_if.slave carrying the input stream and both output streams
// Parameters:
//   Width : data bits per word
//   Depth : entries per output FIFO (power of two, >= 2)
module demux2 #(
    parameter int Width = 32,
    parameter int Depth = 2
) (
    input  logic     clk_i,
    input  logic     rst_i,
    demux2_if.slave  bus
);
    localparam int PW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(Depth);

    // Storage is deliberately left out of reset: empty FIFOs mask their
    // outputs to zero, so stale contents are never visible.
    logic [Width-1:0] mem_q [2][Depth];

    logic [PW-1:0] wptr_q [2];
    logic [PW-1:0] wptr_d [2];
    logic [PW-1:0] rptr_q [2];
    logic [PW-1:0] rptr_d [2];
    logic [CW-1:0] cnt_q  [2];
    logic [CW-1:0] cnt_d  [2];

    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] sel_oh;
    logic [1:0] rdy_in;
    logic       xfer;

    always_comb begin
        full  = '0;
        empty = '0;
        for (int k = 0; k < 2; k++) begin
            full[k]  = (cnt_q[k] == FULL_CNT);
            empty[k] = (cnt_q[k] == '0);
        end
    end

    // ready_o only looks at the registered fill level; a pop in the same
    // cycle does not free the slot until the next cycle, which keeps the
    // consumer ready signals off the producer's ready path.
    assign bus.ready_o = bus.select_i ? ~full[1] : ~full[0];

    assign xfer   = bus.valid_i & bus.ready_o;
    assign sel_oh = {bus.select_i, ~bus.select_i};
    assign rdy_in = {bus.ready1_i, bus.ready0_i};
    assign push   = {2{xfer}} & sel_oh;
    assign pop    = ~empty & rdy_in;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            wptr_d[k] = wptr_q[k];
            rptr_d[k] = rptr_q[k];
            cnt_d[k]  = cnt_q[k];
            if (push[k]) begin
                wptr_d[k] = wptr_q[k] + PW'(1);
            end
            if (pop[k]) begin
                rptr_d[k] = rptr_q[k] + PW'(1);
            end
            case ({push[k], pop[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + CW'(1);
                2'b01:   cnt_d[k] = cnt_q[k] - CW'(1);
                default: cnt_d[k] = cnt_q[k];
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < 2; k++) begin
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                wptr_q[k] <= wptr_d[k];
                rptr_q[k] <= rptr_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    // A write during reset is harmless: the pointers and counts are cleared
    // on the same edge, so the written slot is never read.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k]) begin
                mem_q[k][wptr_q[k]] <= bus.data_i;
            end
        end
    end

    assign bus.valid0_o = ~empty[0];
    assign bus.valid1_o = ~empty[1];
    assign bus.data0_o  = empty[0] ? '0 : mem_q[0][rptr_q[0]];
    assign bus.data1_o  = empty[1] ? '0 : mem_q[1][rptr_q[1]];
endmodule

// File: tb/tb_demux2.sv
module tb_demux2;
    localparam int W = 32;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux2_if #(.Width(W)) bus ();

    demux2 #(.Width(W), .Depth(D)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: one queue per output holding accepted, undelivered words.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    // Words observed leaving each output.
    logic [W-1:0] log0[$];
    logic [W-1:0] log1[$];
    bit chk_en  = 1'b0;
    bit v0_seen = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model update on each rising edge from the pre-edge queue state.
    always @(posedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            bit p0;
            bit p1;
            bit do_push;
            p0 = (q0.size() > 0) && bus.ready0_i;
            p1 = (q1.size() > 0) && bus.ready1_i;
            do_push = bus.valid_i && (bus.select_i ? (q1.size() < D) : (q0.size() < D));
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            if (do_push) begin
                if (bus.select_i) q1.push_back(bus.data_i);
                else              q0.push_back(bus.data_i);
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("valid0", {31'd0, bus.valid0_o}, {31'd0, q0.size() != 0});
            check("valid1", {31'd0, bus.valid1_o}, {31'd0, q1.size() != 0});
            if (q0.size() != 0) check("data0", bus.data0_o, q0[0]);
            if (q1.size() != 0) check("data1", bus.data1_o, q1[0]);
            check("ready", {31'd0, bus.ready_o},
                  {31'd0, bus.select_i ? (q1.size() < D) : (q0.size() < D)});
            if (bus.valid0_o) v0_seen = 1'b1;
            if (!rst && bus.valid0_o && bus.ready0_i) log0.push_back(bus.data0_o);
            if (!rst && bus.valid1_o && bus.ready1_i) log1.push_back(bus.data1_o);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until accepted; optionally toggle ready1_i every cycle.
    task automatic send(input logic s, input logic [W-1:0] d, input bit tog);
        bit acc;
        acc = 1'b0;
        bus.select_i = s;
        bus.data_i   = d;
        bus.valid_i  = 1'b1;
        for (int n = 0; n < 20 && !acc; n++) begin
            #1;
            acc = bus.ready_o;
            @(posedge clk);
            #1;
            if (tog) bus.ready1_i = ~bus.ready1_i;
        end
        bus.valid_i = 1'b0;
        tests++;
        if (!acc) begin
            fails++;
            $display("FAIL send_timeout: word 0x%0h not accepted, expected acceptance within 20 cycles", d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.data_i   = '0;
        bus.select_i = 1'b0;
        bus.valid_i  = 1'b0;
        bus.ready0_i = 1'b0;
        bus.ready1_i = 1'b0;

        // Reset, then idle
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid0", {31'd0, bus.valid0_o}, 32'd0);
        check("rst_valid1", {31'd0, bus.valid1_o}, 32'd0);
        check("rst_data0", bus.data0_o, 32'd0);
        check("rst_data1", bus.data1_o, 32'd0);
        bus.select_i = 1'b0;
        #1 check("rst_ready_sel0", {31'd0, bus.ready_o}, 32'd1);
        bus.select_i = 1'b1;
        #1 check("rst_ready_sel1", {31'd0, bus.ready_o}, 32'd1);
        tick();

        // Alternating routing, consumers always ready
        bus.ready0_i = 1'b1;
        bus.ready1_i = 1'b1;
        send(1'b0, 32'hA0, 1'b0);
        check("alt_v0", {31'd0, bus.valid0_o}, 32'd1);
        check("alt_d0_first", bus.data0_o, 32'hA0);
        send(1'b1, 32'hB1, 1'b0);
        check("alt_d1", bus.data1_o, 32'hB1);
        check("alt_v0_drained", {31'd0, bus.valid0_o}, 32'd0);
        send(1'b0, 32'hA2, 1'b0);
        check("alt_d0_second", bus.data0_o, 32'hA2);
        tick();
        tick();

        // Fill and stall output 0
        bus.ready0_i = 1'b0;
        log0.delete();
        send(1'b0, 32'h11, 1'b0);
        send(1'b0, 32'h22, 1'b0);
        bus.select_i = 1'b0;
        bus.data_i   = 32'h33;
        bus.valid_i  = 1'b1;
        #1 check("stall_ready_sel0", {31'd0, bus.ready_o}, 32'd0);
        bus.select_i = 1'b1;
        #1 check("stall_ready_sel1", {31'd0, bus.ready_o}, 32'd1);
        bus.select_i = 1'b0;
        bus.ready0_i = 1'b1;
        send(1'b0, 32'h33, 1'b0);
        repeat (3) tick();
        check("stall_count", log0.size(), 32'd3);
        check("stall_w0", (log0.size() > 0) ? log0[0] : 32'hDEADDEAD, 32'h11);
        check("stall_w1", (log0.size() > 1) ? log0[1] : 32'hDEADDEAD, 32'h22);
        check("stall_w2", (log0.size() > 2) ? log0[2] : 32'hDEADDEAD, 32'h33);

        // Full output 1 with simultaneous pop
        bus.ready1_i = 1'b0;
        log1.delete();
        send(1'b1, 32'h51, 1'b0);
        send(1'b1, 32'h52, 1'b0);
        bus.ready1_i = 1'b1;
        bus.select_i = 1'b1;
        bus.data_i   = 32'h53;
        bus.valid_i  = 1'b1;
        #1 check("fullpop_ready_blocked", {31'd0, bus.ready_o}, 32'd0);
        tick();
        check("fullpop_ready_freed", {31'd0, bus.ready_o}, 32'd1);
        send(1'b1, 32'h53, 1'b0);
        repeat (3) tick();
        check("fullpop_count", log1.size(), 32'd3);
        check("fullpop_w0", (log1.size() > 0) ? log1[0] : 32'hDEADDEAD, 32'h51);
        check("fullpop_w1", (log1.size() > 1) ? log1[1] : 32'hDEADDEAD, 32'h52);
        check("fullpop_w2", (log1.size() > 2) ? log1[2] : 32'hDEADDEAD, 32'h53);

        // Streaming wrap-around on output 1 with ready1_i toggling
        log1.delete();
        v0_seen = 1'b0;
        bus.ready1_i = 1'b1;
        for (int i = 0; i < 10; i++) send(1'b1, W'(i), 1'b1);
        repeat (12) begin
            tick();
            bus.ready1_i = ~bus.ready1_i;
        end
        bus.ready1_i = 1'b1;
        tick();
        check("stream_count", log1.size(), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check("stream_word", (i < log1.size()) ? log1[i] : 32'hDEADDEAD, W'(i));
        end
        check("stream_v0_idle", {31'd0, v0_seen}, 32'd0);

        // Reset mid-operation
        bus.ready0_i = 1'b0;
        bus.ready1_i = 1'b0;
        send(1'b0, 32'h61, 1'b0);
        send(1'b1, 32'h71, 1'b0);
        check("midrst_pre_v0", {31'd0, bus.valid0_o}, 32'd1);
        check("midrst_pre_v1", {31'd0, bus.valid1_o}, 32'd1);
        log0.delete();
        bus.select_i = 1'b0;
        bus.data_i   = 32'h62;
        bus.valid_i  = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.valid_i = 1'b0;
        check("midrst_v0", {31'd0, bus.valid0_o}, 32'd0);
        check("midrst_v1", {31'd0, bus.valid1_o}, 32'd0);
        check("midrst_d0", bus.data0_o, 32'd0);
        check("midrst_d1", bus.data1_o, 32'd0);
        bus.ready0_i = 1'b1;
        send(1'b0, 32'h63, 1'b0);
        check("midrst_after_v0", {31'd0, bus.valid0_o}, 32'd1);
        check("midrst_after_d0", bus.data0_o, 32'h63);
        repeat (2) tick();
        check("midrst_count", log0.size(), 32'd1);
        check("midrst_word", (log0.size() > 0) ? log0[0] : 32'hDEADDEAD, 32'h63);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
